// File: rtl/shift_issue_stage_pkg.sv
// Shared types and constants for the shift issue stage and its op decoder.
package shift_issue_stage_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 16;
    localparam int RD_W    = 5;

    localparam logic [XLEN-1:0]  SHAMT_MASK = XLEN'((64'd1 << SHAMT_W) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            sign;
        logic            left;
        logic [RD_W-1:0] rd;
    } entry_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational decode of a shift instruction into a shifter entry:
// op -> {sign, left, legal}, operand B selection and shift-amount masking.
module shift_op_decode
    import shift_issue_stage_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [RD_W-1:0] rd,
    output entry_t          entry,
    output logic            legal
);

    logic [XLEN-1:0] src_s;

    // Build the entry; undefined opcodes leave legal low.
    always_comb begin
        entry   = '0;
        legal   = 1'b0;
        src_s   = use_imm ? imm : rs2;
        entry.a = rs1;
        entry.b = src_s & SHAMT_MASK;
        entry.rd = rd;
        case (op)
            OP_SLL: begin
                legal      = 1'b1;
                entry.left = 1'b1;
            end
            OP_SRL: begin
                legal = 1'b1;
            end
            OP_SRA: begin
                legal      = 1'b1;
                entry.sign = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage feeding the shifter: decode, 2-entry skid buffer with registered
// in_ready, flush, illegal-op pulse and a saturating issued-instruction counter.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic             out_sign,
    output logic             out_left,
    output logic [RD_W-1:0]  out_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    entry_t            dec_entry_s;
    logic              dec_legal_s;
    entry_t            main_r, main_n_s;
    entry_t            skid_r, skid_n_s;
    logic              main_vld_r, main_vld_n_s;
    logic              skid_vld_r, skid_vld_n_s;
    logic              in_ready_r;
    logic              illegal_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              accept_s;
    logic              store_s;
    logic              xfer_s;

    shift_op_decode u_decode (
        .op      (in_op),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .use_imm (in_use_imm),
        .rd      (in_rd),
        .entry   (dec_entry_s),
        .legal   (dec_legal_s)
    );

    assign accept_s = in_valid & in_ready_r & ~flush;
    assign store_s  = accept_s & dec_legal_s;
    assign xfer_s   = main_vld_r & out_ready;

    // Skid-buffer next state; skid is only ever empty when a new item can land in it.
    always_comb begin
        main_n_s     = main_r;
        skid_n_s     = skid_r;
        main_vld_n_s = main_vld_r;
        skid_vld_n_s = skid_vld_r;
        if (flush) begin
            main_vld_n_s = 1'b0;
            skid_vld_n_s = 1'b0;
        end else if (!main_vld_r || xfer_s) begin
            if (skid_vld_r) begin
                main_n_s     = skid_r;
                main_vld_n_s = 1'b1;
                skid_vld_n_s = 1'b0;
            end else if (store_s) begin
                main_n_s     = dec_entry_s;
                main_vld_n_s = 1'b1;
            end else begin
                main_vld_n_s = 1'b0;
            end
        end else begin
            if (store_s) begin
                skid_n_s     = dec_entry_s;
                skid_vld_n_s = 1'b1;
            end else begin
                skid_vld_n_s = skid_vld_r;
            end
        end
    end

    // State registers; a transfer on a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r     <= '0;
            skid_r     <= '0;
            main_vld_r <= 1'b0;
            skid_vld_r <= 1'b0;
            in_ready_r <= 1'b1;
            illegal_r  <= 1'b0;
            cnt_r      <= '0;
        end else begin
            main_r     <= main_n_s;
            skid_r     <= skid_n_s;
            main_vld_r <= main_vld_n_s;
            skid_vld_r <= skid_vld_n_s;
            in_ready_r <= ~skid_vld_n_s;
            illegal_r  <= accept_s & ~dec_legal_s;
            if (xfer_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = main_vld_r;
    assign out_a      = main_r.a;
    assign out_b      = main_r.b;
    assign out_sign   = main_r.sign;
    assign out_left   = main_r.left;
    assign out_rd     = main_r.rd;
    assign illegal    = illegal_r;
    assign issued_cnt = cnt_r;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage.
module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_sign;
    logic        out_left;
    logic [4:0]  out_rd;
    logic        illegal;
    logic [15:0] issued_cnt;

    int checks = 0;
    int failures = 0;

    shift_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_sign   (out_sign),
        .out_left   (out_left),
        .out_rd     (out_rd),
        .illegal    (illegal),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm,
                         input logic ui, input logic [4:0] rd);
        in_valid   = v;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_use_imm = ui;
        in_rd      = rd;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_b", out_b, 32'd0);
        check("rst_sign_left", {30'd0, out_sign, out_left}, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_cnt", {16'd0, issued_cnt}, 32'd0);
        step();
        rst = 1'b0;

        // 1: SRA with immediate
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h8000_0010, 32'h0000_0000, 32'd4, 1'b1, 5'd3);
        step();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_a", out_a, 32'h8000_0010);
        check("t1_b", out_b, 32'd4);
        check("t1_sign_left", {30'd0, out_sign, out_left}, 32'd2);
        check("t1_rd", {27'd0, out_rd}, 32'd3);
        check("t1_cnt_before", {16'd0, issued_cnt}, 32'd0);

        // 2: SRL with register amount, upper bits masked
        drive(1'b1, 3'd1, 32'h1234_5678, 32'hFFFF_FF25, 32'd4, 1'b0, 5'd7);
        step();
        check("t1_cnt", {16'd0, issued_cnt}, 32'd1);
        check("t2_a", out_a, 32'h1234_5678);
        check("t2_b", out_b, 32'h0000_0005);
        check("t2_sign_left", {30'd0, out_sign, out_left}, 32'd0);
        check("t2_rd", {27'd0, out_rd}, 32'd7);
        in_valid = 1'b0;
        step();
        check("t2_cnt", {16'd0, issued_cnt}, 32'd2);
        check("t2_empty", {31'd0, out_valid}, 32'd0);

        // 3: stall with three back-to-back SLLs
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'd1, 32'd0, 32'd1, 1'b1, 5'd10);
        step();
        check("t3_ready1", {31'd0, in_ready}, 32'd1);
        check("t3_rd10", {27'd0, out_rd}, 32'd10);
        drive(1'b1, 3'd0, 32'd2, 32'd0, 32'd1, 1'b1, 5'd11);
        step();
        check("t3_ready_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 3'd0, 32'd3, 32'd0, 32'd1, 1'b1, 5'd12);
        step();
        check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
        check("t3_hold_a", out_a, 32'd1);
        step();
        check("t3_stable_rd", {27'd0, out_rd}, 32'd10);
        check("t3_stable_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        check("t3_order_rd11", {27'd0, out_rd}, 32'd11);
        check("t3_cnt3", {16'd0, issued_cnt}, 32'd3);
        check("t3_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("t3_order_rd12", {27'd0, out_rd}, 32'd12);
        check("t3_a12", out_a, 32'd3);
        check("t3_left", {31'd0, out_left}, 32'd1);
        check("t3_cnt4", {16'd0, issued_cnt}, 32'd4);
        in_valid = 1'b0;
        step();
        check("t3_cnt5", {16'd0, issued_cnt}, 32'd5);
        check("t3_drained", {31'd0, out_valid}, 32'd0);

        // 4: illegal op
        drive(1'b1, 3'd5, 32'd9, 32'd0, 32'd0, 1'b1, 5'd15);
        step();
        check("t4_illegal", {31'd0, illegal}, 32'd1);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_cnt", {16'd0, issued_cnt}, 32'd5);
        in_valid = 1'b0;
        step();
        check("t4_pulse_end", {31'd0, illegal}, 32'd0);
        check("t4_valid2", {31'd0, out_valid}, 32'd0);

        // 5: flush with both entries full
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 32'd20, 32'd0, 32'd2, 1'b1, 5'd20);
        step();
        in_rd = 5'd21;
        step();
        check("t5_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        in_rd = 5'd22;
        step();
        check("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        check("t5_flush_ready", {31'd0, in_ready}, 32'd1);
        in_op = 3'd5;
        step();
        check("t5_flush_no_illegal", {31'd0, illegal}, 32'd0);
        check("t5_flush_drop", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b1, 3'd0, 32'd30, 32'd0, 32'd1, 1'b1, 5'd30);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_flush_xfer_cnt", {16'd0, issued_cnt}, 32'd6);
        check("t5_flush_xfer_valid", {31'd0, out_valid}, 32'd0);
        step();
        step();
        check("t5_nothing_later", {31'd0, out_valid}, 32'd0);
        check("t5_cnt_stable", {16'd0, issued_cnt}, 32'd6);

        // 6: asynchronous reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'hDEAD_BEEF, 32'd0, 32'd7, 1'b1, 5'd9);
        step();
        step();
        check("t6_stalled", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", {31'd0, out_valid}, 32'd0);
        check("t6_async_ready", {31'd0, in_ready}, 32'd1);
        check("t6_async_a", out_a, 32'd0);
        check("t6_async_cnt", {16'd0, issued_cnt}, 32'd0);
        check("t6_async_sign", {31'd0, out_sign}, 32'd0);
        step();
        rst = 1'b0;

        // 6: saturate the counter
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 32'd1, 32'd0, 32'd1, 1'b1, 5'd1);
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        check("t6_cnt_max", {16'd0, issued_cnt}, 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("t6_cnt_hold", {16'd0, issued_cnt}, 32'h0000_FFFF);
        in_valid = 1'b0;
        step();
        step();
        check("t6_cnt_final", {16'd0, issued_cnt}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
